// File: rtl/temp_pwm_ctrl.sv
// temp_pwm_ctrl
//   Autonomous temperature-to-PWM sequencer. The block samples the ADC on a
//   periodic strobe and averages 2^AVG_LOG2 samples. A restoring divider turns
//   the average into whole degrees C. The temperature is mapped to a 0..100 %
//   duty, which drives a PWM generator whose duty only changes at period
//   boundaries. A manual override replaces the temperature-derived duty.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       run enable; low parks the FSM in IDLE and silences the PWM
//   adc_value    12-bit ADC result (level signal, sampled on the strobe)
//   manual_en    1 = take duty from manual_duty
//   manual_duty  manual duty in %, values above 100 clamp to 100
//   temp_c       last converted temperature in degrees C
//   temp_valid   one-cycle pulse when temp_c updates
//   duty         duty (%) in effect for the current PWM period
//   pwm_out      PWM output
//   busy         high while converting / updating
module temp_pwm_ctrl #(
    parameter int SAMPLE_DIV = 1000,
    parameter int AVG_LOG2   = 3,
    parameter int DIVISOR    = 10,
    parameter int T_LOW      = 30,
    parameter int STEP       = 10,
    parameter int PWM_PERIOD = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] adc_value,
    input  logic        manual_en,
    input  logic [6:0]  manual_duty,
    output logic [8:0]  temp_c,
    output logic        temp_valid,
    output logic [6:0]  duty,
    output logic        pwm_out,
    output logic        busy
);
    localparam int NSAMP  = 1 << AVG_LOG2;
    localparam int SUM_W  = 12 + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int TICK_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PCNT_W = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;
    localparam int MV_W   = 13;
    // Partial remainder stays below DIVISOR; one extra bit holds the shifted value.
    localparam int REM_W  = $clog2(DIVISOR) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CONVERT, S_UPDATE} state_t;

    state_t             r_state;
    logic [TICK_W-1:0]  r_tick;
    logic [SUM_W-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic [MV_W-1:0]    r_num;      // dividend in, quotient out (bits shift in at LSB)
    logic [REM_W-1:0]   r_rem;
    logic [3:0]         r_step;
    logic [8:0]         r_temp_c;
    logic               r_temp_valid;
    logic [6:0]         r_auto_duty;
    logic               r_en;
    logic [PCNT_W-1:0]  r_pcnt;
    logic [6:0]         r_duty;
    logic               r_pwm;

    logic               w_strobe;
    logic [SUM_W-1:0]   w_sum_nxt;
    logic [11:0]        w_avg;
    logic [MV_W-1:0]    w_mv;
    logic [REM_W:0]     w_rem_sh;
    logic               w_qbit;
    logic [REM_W-1:0]   w_rem_sub;
    logic [8:0]         w_temp_sat;
    logic [6:0]         w_auto_duty;
    int                 w_over;
    logic [6:0]         w_next_duty;
    logic               w_boundary;

    function automatic logic [PCNT_W:0] scale_duty(input logic [6:0] d);
        if (PWM_PERIOD == 100) return (PCNT_W+1)'(d);
        else                   return (PCNT_W+1)'((int'(d) * PWM_PERIOD) / 100);
    endfunction

    // ---------------- sample strobe ----------------
    assign w_strobe = enable && (r_tick == TICK_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_tick <= '0;
        else if (!enable)     r_tick <= '0;
        else if (w_strobe)    r_tick <= '0;
        else                  r_tick <= r_tick + 1'b1;
    end

    // ---------------- datapath ----------------
    // The final strobe's sample is folded in on the way into CONVERT.
    assign w_sum_nxt = r_sum + SUM_W'(adc_value);
    assign w_avg     = 12'(w_sum_nxt >> AVG_LOG2);
    assign w_mv      = {1'b0, w_avg} + {3'b000, w_avg[11:2]};

    assign w_rem_sh  = {r_rem, r_num[MV_W-1]};
    assign w_qbit    = (w_rem_sh >= (REM_W+1)'(DIVISOR));
    assign w_rem_sub = REM_W'(w_rem_sh - (REM_W+1)'(DIVISOR));

    assign w_temp_sat = (r_num > MV_W'(511)) ? 9'd511 : r_num[8:0];

    always_comb begin
        w_over      = 0;
        w_auto_duty = '0;
        if (int'(w_temp_sat) > T_LOW) begin
            w_over      = (int'(w_temp_sat) - T_LOW) * STEP;
            w_auto_duty = (w_over >= 100) ? 7'd100 : 7'(w_over);
        end
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_num        <= '0;
            r_rem        <= '0;
            r_step       <= '0;
            r_temp_c     <= '0;
            r_temp_valid <= 1'b0;
            r_auto_duty  <= '0;
        end else begin
            r_temp_valid <= 1'b0;
            if (!enable) begin
                // Abort anything in flight; temp_c and auto duty keep their values.
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_ACCUM;
                    end
                    S_ACCUM: begin
                        if (w_strobe) begin
                            r_sum <= w_sum_nxt;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(NSAMP - 1)) begin
                                r_num   <= w_mv;
                                r_rem   <= '0;
                                r_step  <= '0;
                                r_state <= S_CONVERT;
                            end
                        end
                    end
                    S_CONVERT: begin
                        // One restoring step per clock, MSB first.
                        r_num  <= {r_num[MV_W-2:0], w_qbit};
                        r_rem  <= w_qbit ? w_rem_sub : w_rem_sh[REM_W-1:0];
                        r_step <= r_step + 4'd1;
                        if (r_step == 4'(MV_W - 1)) r_state <= S_UPDATE;
                    end
                    S_UPDATE: begin
                        r_temp_c     <= w_temp_sat;
                        r_temp_valid <= 1'b1;
                        r_auto_duty  <= w_auto_duty;
                        r_sum        <= '0;
                        r_cnt        <= '0;
                        r_state      <= S_ACCUM;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- PWM ----------------
    assign w_next_duty = manual_en ? ((manual_duty > 7'd100) ? 7'd100 : manual_duty)
                                   : r_auto_duty;
    // A period starts on wrap or on the first enabled cycle after enable rises.
    assign w_boundary  = !r_en || (r_pcnt == PCNT_W'(PWM_PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en   <= 1'b0;
            r_pcnt <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_en <= enable;
            if (!enable) begin
                r_pcnt <= '0;
                r_pwm  <= 1'b0;
            end else if (w_boundary) begin
                // r_pwm tracks the counter value being entered, so duty 100
                // stays high straight through the wrap.
                r_pcnt <= '0;
                r_duty <= w_next_duty;
                r_pwm  <= (scale_duty(w_next_duty) != '0);
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
                r_pwm  <= (({1'b0, r_pcnt} + 1'b1) < scale_duty(r_duty));
            end
        end
    end

    assign temp_c     = r_temp_c;
    assign temp_valid = r_temp_valid;
    assign duty       = r_duty;
    assign pwm_out    = r_pwm & r_en;
    assign busy       = (r_state == S_CONVERT) || (r_state == S_UPDATE);

endmodule

// File: tb/tb_temp_pwm_ctrl.sv
// Self-checking bench for temp_pwm_ctrl: randomized and directed stimulus
// against a transaction-level reference model (sample schedule, averaging,
// integer conversion, duty mapping, period-boundary duty loading).
module tb_temp_pwm_ctrl;
  localparam int SD = 4;
  localparam int NS = 8;

  logic        clk = 1'b0;
  logic        reset, enable, manual_en;
  logic [11:0] adc_value;
  logic [6:0]  manual_duty;
  logic [8:0]  temp_c;
  logic        temp_valid;
  logic [6:0]  duty;
  logic        pwm_out, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int         m_n, m_cnt, m_sum, m_busy_end;
  logic [8:0] m_temp, m_pend;
  logic [6:0] m_duty, m_auto;
  logic       m_pwm, m_valid, m_busy;

  always #5 clk = ~clk;

  temp_pwm_ctrl #(
    .SAMPLE_DIV(SD), .AVG_LOG2(3), .DIVISOR(10),
    .T_LOW(30), .STEP(10), .PWM_PERIOD(100)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_value(adc_value),
    .manual_en(manual_en), .manual_duty(manual_duty),
    .temp_c(temp_c), .temp_valid(temp_valid), .duty(duty),
    .pwm_out(pwm_out), .busy(busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] ref_temp(input int sum);
    int avg, mv, t;
    avg = sum / NS;
    mv  = avg + avg / 4;
    t   = mv / 10;
    if (t > 511) t = 511;
    return 9'(t);
  endfunction

  function automatic logic [6:0] ref_duty(input int t);
    if (t <= 30) return 7'd0;
    return ((t - 30) * 10 > 100) ? 7'd100 : 7'((t - 30) * 10);
  endfunction

  task automatic model_clear_run();
    m_n = 0; m_cnt = 0; m_sum = 0; m_busy_end = 0;
    m_valid = 1'b0; m_pwm = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_run();
    m_temp = '0; m_pend = '0; m_duty = '0; m_auto = '0;
  endtask

  // Drive one clock with the given ADC level and advance the model; returns at negedge.
  task automatic tick(input logic [11:0] adc);
    int ph;
    adc_value = adc;
    @(posedge clk);
    if (enable) begin
      m_n++;
      ph = (m_n - 1) % 100;
      if (ph == 0) m_duty = manual_en ? ((manual_duty > 7'd100) ? 7'd100 : manual_duty) : m_auto;
      m_pwm = (ph < int'(m_duty));
      if ((m_n % SD) == 0 && m_n > m_busy_end) begin
        m_sum += int'(adc);
        m_cnt++;
        if (m_cnt == NS) begin
          m_pend = ref_temp(m_sum);
          m_busy_end = m_n + 14;
          m_sum = 0; m_cnt = 0;
        end
      end
      m_valid = (m_n == m_busy_end);
      if (m_valid) begin
        m_temp = m_pend;
        m_auto = ref_duty(int'(m_pend));
      end
      m_busy = (m_busy_end > 0) && (m_n >= m_busy_end - 14) && (m_n < m_busy_end);
    end else begin
      model_clear_run();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++; if (temp_c !== 9'd0)    begin n_bad++; $display("FAIL reset_temp_c: got %0d want 0", temp_c); end
    n_cmp++; if (temp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_temp_valid: got %b want 0", temp_valid); end
    n_cmp++; if (duty !== 7'd0)      begin n_bad++; $display("FAIL reset_duty: got %0d want 0", duty); end
    n_cmp++; if (pwm_out !== 1'b0)   begin n_bad++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_scale();
    int hi = 0;
    enable = 1'b1; manual_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(12'd819);
      n_cmp++;
      if ({temp_valid, temp_c, duty, pwm_out, busy} !== {m_valid, m_temp, m_duty, m_pwm, m_busy}) begin
        n_bad++;
        $display("FAIL full_scale n=%0d got v%b t%0d d%0d p%b b%b want v%b t%0d d%0d p%b b%b",
                 m_n, temp_valid, temp_c, duty, pwm_out, busy, m_valid, m_temp, m_duty, m_pwm, m_busy);
      end
      if (m_valid) begin
        n_cmp++;
        if (temp_c !== 9'd102) begin n_bad++; $display("FAIL full_scale_temp: got %0d want 102", temp_c); end
      end
      if (m_n > 100) hi += int'(pwm_out);
    end
    n_cmp++;
    if (hi != 100) begin n_bad++; $display("FAIL full_scale_high: got %0d high clocks want 100", hi); end
  endtask

  task automatic test_half_duty();
    int hi = 0, pd = 0, ph;
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      tick(12'd280);
      n_cmp++;
      if ({temp_valid, temp_c, duty, pwm_out, busy} !== {m_valid, m_temp, m_duty, m_pwm, m_busy}) begin
        n_bad++;
        $display("FAIL half_duty n=%0d got v%b t%0d d%0d p%b b%b want v%b t%0d d%0d p%b b%b",
                 m_n, temp_valid, temp_c, duty, pwm_out, busy, m_valid, m_temp, m_duty, m_pwm, m_busy);
      end
      ph = (m_n - 1) % 100;
      if (ph == 0) begin pd = int'(duty); hi = 0; end
      hi += int'(pwm_out);
      if (ph == 99 && pd == 50 && !done) begin
        done = 1;
        n_cmp++;
        if (hi != 50) begin n_bad++; $display("FAIL half_duty_high: got %0d want 50", hi); end
      end
    end
    n_cmp++;
    if (!done || temp_c !== 9'd35) begin
      n_bad++; $display("FAIL half_duty_final: got temp %0d period_seen %0d want temp 35 period_seen 1", temp_c, done);
    end
  endtask

  task automatic test_threshold();
    for (int i = 0; i < 150; i++) begin
      tick(12'd240);
      n_cmp++;
      if ({temp_valid, temp_c, duty, pwm_out, busy} !== {m_valid, m_temp, m_duty, m_pwm, m_busy}) begin
        n_bad++;
        $display("FAIL threshold_lo n=%0d got v%b t%0d d%0d p%b b%b want v%b t%0d d%0d p%b b%b",
                 m_n, temp_valid, temp_c, duty, pwm_out, busy, m_valid, m_temp, m_duty, m_pwm, m_busy);
      end
    end
    n_cmp++;
    if (temp_c !== 9'd30) begin n_bad++; $display("FAIL threshold_30: got %0d want 30", temp_c); end
    for (int i = 0; i < 250; i++) begin
      tick(12'd248);
      n_cmp++;
      if ({temp_valid, temp_c, duty, pwm_out, busy} !== {m_valid, m_temp, m_duty, m_pwm, m_busy}) begin
        n_bad++;
        $display("FAIL threshold_hi n=%0d got v%b t%0d d%0d p%b b%b want v%b t%0d d%0d p%b b%b",
                 m_n, temp_valid, temp_c, duty, pwm_out, busy, m_valid, m_temp, m_duty, m_pwm, m_busy);
      end
    end
    n_cmp++;
    if (temp_c !== 9'd31 || duty !== 7'd10) begin
      n_bad++; $display("FAIL threshold_31: got temp %0d duty %0d want temp 31 duty 10", temp_c, duty);
    end
  endtask

  // 240/320 alternate on accepted samples; strobes that land in the busy
  // window see 4095, which would skew the average if they were accumulated.
  task automatic test_alternating();
    logic [11:0] a;
    for (int i = 0; i < 200; i++) begin
      if (m_n + 1 <= m_busy_end) a = 12'd4095;
      else                      a = m_cnt[0] ? 12'd320 : 12'd240;
      tick(a);
      n_cmp++;
      if ({temp_valid, temp_c, duty, pwm_out, busy} !== {m_valid, m_temp, m_duty, m_pwm, m_busy}) begin
        n_bad++;
        $display("FAIL alternating n=%0d got v%b t%0d d%0d p%b b%b want v%b t%0d d%0d p%b b%b",
                 m_n, temp_valid, temp_c, duty, pwm_out, busy, m_valid, m_temp, m_duty, m_pwm, m_busy);
      end
    end
    n_cmp++;
    if (temp_c !== 9'd35) begin n_bad++; $display("FAIL alternating_temp: got %0d want 35", temp_c); end
  endtask

  task automatic test_manual();
    bit ok;
    int hi = 0;
    manual_en = 1'b1; manual_duty = 7'd120;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(12'd280);
      ok = ((m_n - 1) % 100 == 0);
    end
    n_cmp++;
    if (!ok || duty !== 7'd100) begin n_bad++; $display("FAIL manual_clamp: got duty %0d want 100", duty); end
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(12'd280);
      ok = ((m_n - 1) % 100 == 30);
    end
    manual_duty = 7'd25;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(12'd280);
      n_cmp++;
      if ({temp_valid, temp_c, duty, pwm_out, busy} !== {m_valid, m_temp, m_duty, m_pwm, m_busy}) begin
        n_bad++;
        $display("FAIL manual_mid n=%0d got v%b t%0d d%0d p%b b%b want v%b t%0d d%0d p%b b%b",
                 m_n, temp_valid, temp_c, duty, pwm_out, busy, m_valid, m_temp, m_duty, m_pwm, m_busy);
      end
      ok = ((m_n - 1) % 100 == 0);
      if (!ok) begin
        n_cmp++;
        if (duty !== 7'd100 || pwm_out !== 1'b1) begin
          n_bad++; $display("FAIL manual_old_period: got duty %0d pwm %b want 100 1", duty, pwm_out);
        end
      end
    end
    n_cmp++;
    if (!ok || duty !== 7'd25) begin n_bad++; $display("FAIL manual_new_duty: got %0d want 25", duty); end
    hi = int'(pwm_out);
    for (int i = 0; i < 99; i++) begin
      tick(12'd280);
      hi += int'(pwm_out);
    end
    n_cmp++;
    if (hi != 25) begin n_bad++; $display("FAIL manual_high: got %0d want 25", hi); end
    manual_en = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit ok = 0;
    bit vseen = 0;
    logic [8:0] tc;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(12'd300);
      ok = m_busy && (m_n == m_busy_end - 10);
    end
    n_cmp++;
    if (!ok || busy !== 1'b1) begin n_bad++; $display("FAIL drop_reach_convert: got busy %b want 1", busy); end
    tc = temp_c;
    enable = 1'b0;
    tick(12'd300);
    n_cmp++;
    if ({busy, pwm_out, temp_valid} !== 3'b000 || temp_c !== tc) begin
      n_bad++; $display("FAIL drop_next_clock: got busy%b pwm%b v%b t%0d want 0 0 0 t%0d", busy, pwm_out, temp_valid, temp_c, tc);
    end
    for (int i = 0; i < 30; i++) begin
      tick(12'd300);
      if (temp_valid !== 1'b0 || temp_c !== tc || pwm_out !== 1'b0) vseen = 1;
    end
    n_cmp++;
    if (vseen) begin n_bad++; $display("FAIL drop_idle_quiet: got activity 1 want 0"); end
    enable = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick(12'd300);
      n_cmp++;
      if ({temp_valid, temp_c, duty, pwm_out, busy} !== {m_valid, m_temp, m_duty, m_pwm, m_busy}) begin
        n_bad++;
        $display("FAIL drop_resume n=%0d got v%b t%0d d%0d p%b b%b want v%b t%0d d%0d p%b b%b",
                 m_n, temp_valid, temp_c, duty, pwm_out, busy, m_valid, m_temp, m_duty, m_pwm, m_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 37 == 0) begin
        manual_en   = 1'($urandom_range(0, 1));
        manual_duty = 7'($urandom_range(0, 127));
      end
      tick(12'($urandom_range(0, 4095)));
      n_cmp++;
      if ({temp_valid, temp_c, duty, pwm_out, busy} !== {m_valid, m_temp, m_duty, m_pwm, m_busy}) begin
        n_bad++;
        $display("FAIL random n=%0d got v%b t%0d d%0d p%b b%b want v%b t%0d d%0d p%b b%b",
                 m_n, temp_valid, temp_c, duty, pwm_out, busy, m_valid, m_temp, m_duty, m_pwm, m_busy);
      end
    end
    manual_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    manual_en = 1'b1; manual_duty = 7'd90;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick(12'd819);
      ok = (m_duty == 7'd90) && ((m_n - 1) % 100 == 40);
    end
    n_cmp++;
    if (!ok || pwm_out !== 1'b1) begin n_bad++; $display("FAIL reset_mid_pre: got pwm %b want 1", pwm_out); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({temp_c, temp_valid, duty, pwm_out, busy} !== 19'd0) begin
      n_bad++; $display("FAIL reset_mid_async: got t%0d v%b d%0d p%b b%b want all 0", temp_c, temp_valid, duty, pwm_out, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    manual_en = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick(12'd280);
      n_cmp++;
      if ({temp_valid, temp_c, duty, pwm_out, busy} !== {m_valid, m_temp, m_duty, m_pwm, m_busy}) begin
        n_bad++;
        $display("FAIL reset_mid_after n=%0d got v%b t%0d d%0d p%b b%b want v%b t%0d d%0d p%b b%b",
                 m_n, temp_valid, temp_c, duty, pwm_out, busy, m_valid, m_temp, m_duty, m_pwm, m_busy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; manual_en = 1'b0; manual_duty = '0; adc_value = '0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_full_scale();
    test_half_duty();
    test_threshold();
    test_alternating();
    test_manual();
    test_enable_drop();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/temp_pwm_ctrl.md
Name: temp_pwm_ctrl

Overview:
Autonomous sequencer between the 12-bit ADC input and the PWM output of the peripherals subsystem.
- Samples adc_value on a periodic tick and averages 2^AVG_LOG2 samples.
- Converts the average to integer °C with a sequential divider and maps temperature to a 0–100 % duty.
- Drives the PWM generator.
- A manual override, driven from the switches, bypasses the temperature-to-duty mapping.

Parameters:
- SAMPLE_DIV, 1000: clocks between ADC samples (≥2).
- AVG_LOG2, 3: log2 of samples per average (8).
- DIVISOR, 10: mV per °C (LM35 sensor); constant divider for conversion.
- T_LOW, 30: °C at and below which auto duty = 0.
- STEP, 10: duty % added per °C above T_LOW.
- PWM_PERIOD, 100: PWM counter period in clocks; duty is in % of this.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  controller run enable.
- adc_value  in  12  ADC conversion result, level signal.
- manual_en  in  1  1 = use manual_duty instead of auto duty.
- manual_duty  in  7  manual duty in %; values >100 clamp to 100.
- temp_c  out  9  last converted temperature, °C.
- temp_valid  out  1  one-cycle pulse when temp_c updates.
- duty  out  7  duty in effect for the current PWM period.
- pwm_out  out  1  PWM output.
- busy  out  1  high in CONVERT and UPDATE.

Behaviour:
- Reset (async, active-high):
  - All state cleared.
  - Outputs: temp_c=0, temp_valid=0, duty=0, pwm_out=0, busy=0; FSM=IDLE.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while enable=1.
  - The sample strobe fires when the count is SAMPLE_DIV-1, then the counter wraps to 0.
  - Cleared when enable=0.
- FSM states: IDLE, ACCUM, CONVERT, UPDATE.
  - IDLE → ACCUM when enable=1; the sum and sample count are cleared.
  - ACCUM:
    - On each strobe, sum += adc_value. Sum is 12+AVG_LOG2 bits, cannot overflow.
    - After the 2^AVG_LOG2-th sample, go to CONVERT. That final strobe's sample is included.
  - CONVERT:
    - avg = sum >> AVG_LOG2.
    - mv = avg + (avg >> 2), 13 bits, truncating.
    - Restoring division mv / DIVISOR, one quotient bit per clock, exactly 13 cycles. Remainder discarded.
    - Quotient saturates to 511.
  - UPDATE (1 cycle):
    - temp_c <= quotient; temp_valid=1 for this cycle only.
    - Auto duty = 0 if temp ≤ T_LOW, else min((temp−T_LOW)*STEP, 100).
    - Next state ACCUM with the sum cleared.
  - Strobes arriving during CONVERT/UPDATE are dropped; the tick counter keeps running.
  - Latency: the final-sample strobe is followed by 13 CONVERT cycles, then UPDATE; temp_valid asserts 14 clocks after the strobe edge.
- enable=0 in any state:
  - Next clock: FSM=IDLE, an in-flight conversion is aborted, and temp_c and duty hold their values.
  - pwm_out is forced 0 combinationally from the enable register; the PWM counter is cleared.
- Duty selection:
  - next_duty = manual_en ? min(manual_duty, 100) : auto duty.
  - duty is loaded from next_duty only at the PWM period boundary: counter wrap PWM_PERIOD-1 → 0, or the first cycle after enable rises. This gives glitch-free periods.
  - Changes to manual_en or manual_duty mid-period take effect on the next period.
- PWM:
  - Counter 0..PWM_PERIOD-1; pwm_out registered = (cnt < duty scaled).
  - Scaled duty = duty*PWM_PERIOD/100. It equals duty at the default PWM_PERIOD=100, so no divider is needed there.
  - Duty 0 → constant 0; duty 100 → constant 1, no single-cycle low pulse at wrap.
- Reset mid-conversion: immediate return to reset values; no temp_valid pulse.

Test Plan:
1. SAMPLE_DIV=4; adc_value=819 constant, enable=1 → after 8 strobes, temp_valid pulses once with temp_c=102 (mv=1023) and auto duty=100; from the next period, pwm_out stays high continuously.
2. adc_value=280 → temp_c=35, duty=50; pwm_out is high for exactly 50 of every 100 clocks, with duty changing only at a wrap.
3. adc_value=240 → temp_c=30, duty=0, pwm_out constant 0. Then adc_value=248 (mv=310) → temp_c=31, duty=10.
4. Alternating samples 240/320 over the 8 samples → avg=280, temp_c=35. Confirms averaging, and that a strobe during CONVERT is not accumulated.
5. manual_en=1, manual_duty=120 → duty=100. manual_duty=25 applied mid-period → the old duty finishes that period, then 25-clock-high periods follow.
6. enable dropped during CONVERT → next clock: FSM=IDLE, pwm_out=0, no temp_valid, temp_c unchanged. Async reset pulsed mid-period → all outputs 0 immediately.
